// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, counter
// widths and a one-hot to index helper.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    localparam int GAP_CNT_W = 8;
    localparam int TMO_CNT_W = 8;

    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter handshake bundle; the scheduler is the master.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;

    modport master (input req, req_data, tx_busy, output ack, tx_start, tx_data);
    modport slave  (output req, req_data, tx_busy, input ack, tx_start, tx_data);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin selector: searches from last_grant+1 (mod NUM_REQ) upward.
module rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [NUM_REQ-1:0] grant_s;
    logic               found_s;
    logic               hit_s;

    // Walk the priority ring once; the first requesting slot wins.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s      = !found_s && req[i] && (((int'(last_grant) + k) % NUM_REQ) == i);
                grant_s[i] = grant_s[i] | hit_s;
                found_s    = found_s | hit_s;
            end
        end
    end

    assign grant = grant_s;
    assign valid = found_s;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates NUM_REQ byte requesters onto a single UART transmitter, with a
// busy-rise timeout and an enforced idle gap between frames.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_scheduler_if.master  bus,
    output logic                 idle,
    output logic                 err_timeout
);

    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        (GAP_CYCLES == 0) ? {GAP_CNT_W{1'b0}} : GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST =
        (BUSY_TIMEOUT == 0) ? {TMO_CNT_W{1'b0}} : TMO_CNT_W'(BUSY_TIMEOUT - 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic                 arb_valid_s;
    logic                 grant_take_s;
    logic                 tmo_hit_s;
    logic [7:0]           data_sel_s;
    logic [NUM_REQ-1:0]   ack_r;
    logic                 tx_start_r;
    logic [7:0]           tx_data_r;
    logic [2:0]           last_grant_r;
    logic [GAP_CNT_W-1:0] gap_cnt_r;
    logic [TMO_CNT_W-1:0] tmo_cnt_r;
    logic                 err_r;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .valid      (arb_valid_s)
    );

    // Mux the winning requester's byte.
    always_comb begin
        data_sel_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_sel_s = data_sel_s | (bus.req_data[8*i +: 8] & {8{grant_s[i]}});
        end
    end

    // Next-state logic; a grant is only taken from IDLE with the line free.
    always_comb begin
        state_nxt_s  = state_r;
        grant_take_s = 1'b0;
        tmo_hit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s && !bus.tx_busy) begin
                    state_nxt_s  = ST_ISSUE;
                    grant_take_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_GAP;
                    tmo_hit_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output strobes, latched byte, round-robin pointer, counters and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r        <= '0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            last_grant_r <= 3'(NUM_REQ - 1);
            gap_cnt_r    <= '0;
            tmo_cnt_r    <= '0;
            err_r        <= 1'b0;
        end else begin
            tx_start_r <= grant_take_s;
            ack_r      <= grant_take_s ? grant_s : '0;
            if (grant_take_s) begin
                tx_data_r    <= data_sel_s;
                last_grant_r <= onehot_idx(8'(grant_s));
            end
            tmo_cnt_r <= (state_r == ST_WAIT_BUSY) ? tmo_cnt_r + 8'd1 : 8'd0;
            gap_cnt_r <= (state_r == ST_GAP) ? gap_cnt_r + 8'd1 : 8'd0;
            if (tmo_hit_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.ack      = ack_r;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
    assign idle         = (state_r == ST_IDLE) && !(|bus.req);
    assign err_timeout  = err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple transmitter and requester model.
module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int GAP   = 16;
    localparam int TMO   = 8;
    localparam int FRAME = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic idle;
    logic err_timeout;

    uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ      (N),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .idle        (idle),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         auto_busy;
    bit         ext_busy;
    bit         model_busy;
    bit         start_prev;
    int         frame_left;
    logic [N-1:0] hold;
    int         start_cnt, ack_cnt, viol;
    int         start_cyc, fall_cyc;
    int         grant_log[$];
    logic [7:0] data_log[$];
    int         t_ref;
    int         guard;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then run the transmitter and requester models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (model_busy) begin
            frame_left--;
            if (frame_left == 0) begin
                model_busy = 1'b0;
                fall_cyc   = cyc;
            end
        end
        if (start_prev && auto_busy) begin
            model_busy = 1'b1;
            frame_left = FRAME;
        end
        start_prev = bus.tx_start;
        if (bus.tx_start) begin
            start_cnt++;
            start_cyc = cyc;
            data_log.push_back(bus.tx_data);
        end
        if ((bus.ack != '0) != bus.tx_start) viol++;
        if (bus.ack != '0) begin
            ack_cnt++;
            if (!$onehot(bus.ack)) viol++;
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    grant_log.push_back(i);
                    if (!hold[i]) bus.req[i] = 1'b0;
                end
            end
        end
        bus.tx_busy = model_busy | ext_busy;
    endtask

    task automatic clear_models();
        bus.req      = '0;
        bus.req_data = '0;
        hold         = '0;
        model_busy   = 1'b0;
        ext_busy     = 1'b0;
        start_prev   = 1'b0;
        auto_busy    = 1'b1;
        bus.tx_busy  = 1'b0;
        start_cnt    = 0;
        ack_cnt      = 0;
        grant_log.delete();
        data_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_models();
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_start(input string tag, input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tx_start && n < max);
        check_eq(tag, 32'(bus.tx_start), 32'd1);
    endtask

    initial begin
        viol  = 0;
        rst_n = 1'b1;
        clear_models();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("rst_ack", 32'(bus.ack), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        check_eq("rst_idle", 32'(idle), 32'd1);

        // Single requester, minimum latency, then the enforced gap.
        do_reset();
        bus.req_data[7:0] = 8'hA5;
        bus.req           = 4'b0001;
        step();
        check_eq("single_latency", 32'(bus.tx_start), 32'd1);
        check_eq("single_ack", 32'(bus.ack), 32'h1);
        check_eq("single_data", 32'(bus.tx_data), 32'hA5);
        bus.req_data[7:0] = 8'h3C;
        bus.req           = 4'b0001;
        wait_start("single_second_seen", 100);
        check_eq("single_second_data", 32'(bus.tx_data), 32'h3C);
        check_eq("single_gap", 32'(start_cyc - fall_cyc), 32'(GAP + 2));
        check_eq("single_starts", 32'(start_cnt), 32'd2);
        check_eq("single_acks", 32'(ack_cnt), 32'd2);

        // All requesters held high: strict rotation.
        do_reset();
        hold = 4'b1111;
        for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = 8'h10 + 8'(i);
        bus.req = 4'b1111;
        guard = 0;
        while (ack_cnt < 8 && guard < 1000) begin
            step();
            guard++;
        end
        hold    = '0;
        bus.req = '0;
        check_eq("rr_acks", 32'(ack_cnt), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("rr_order%0d", k), 32'(grant_log[k]), 32'(k % 4));
            check_eq($sformatf("rr_data%0d", k), 32'(data_log[k]), 32'h10 + 32'(k % 4));
        end

        // Transmitter never goes busy: timeout, byte dropped, back to idle.
        do_reset();
        auto_busy          = 1'b0;
        bus.req_data[15:8] = 8'h5A;
        bus.req            = 4'b0010;
        wait_start("tmo_start_seen", 20);
        t_ref = cyc;
        guard = 0;
        while (!err_timeout && guard < 50) begin
            step();
            guard++;
        end
        check_eq("tmo_latency", 32'(cyc - t_ref), 32'(TMO + 1));
        check_eq("tmo_err", 32'(err_timeout), 32'd1);
        repeat (40) step();
        check_eq("tmo_idle", 32'(idle), 32'd1);
        check_eq("tmo_acks", 32'(ack_cnt), 32'd1);
        check_eq("tmo_starts", 32'(start_cnt), 32'd1);
        check_eq("tmo_sticky", 32'(err_timeout), 32'd1);
        check_eq("tmo_data_held", 32'(bus.tx_data), 32'h5A);

        // Reset in WAIT_DONE; err from the previous case still set until then.
        auto_busy           = 1'b1;
        bus.req_data[23:16] = 8'h77;
        bus.req             = 4'b0100;
        wait_start("rst_mid_start_seen", 20);
        check_eq("rst_mid_ack", 32'(bus.ack), 32'h4);
        repeat (4) step();
        check_eq("rst_mid_busy", 32'(bus.tx_busy), 32'd1);
        check_eq("rst_mid_err_before", 32'(err_timeout), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("rst_mid_ack_clr", 32'(bus.ack), 32'd0);
        check_eq("rst_mid_tx_data", 32'(bus.tx_data), 32'h00);
        check_eq("rst_mid_err", 32'(err_timeout), 32'd0);
        clear_models();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check_eq("rst_no_reissue", 32'(start_cnt + ack_cnt), 32'd0);
        bus.req_data[7:0]   = 8'h11;
        bus.req_data[23:16] = 8'h33;
        bus.req             = 4'b0101;
        guard = 0;
        while (ack_cnt < 2 && guard < 200) begin
            step();
            guard++;
        end
        check_eq("rst_first_grant", 32'(grant_log[0]), 32'd0);
        check_eq("rst_second_grant", 32'(grant_log[1]), 32'd2);
        check_eq("rst_first_data", 32'(data_log[0]), 32'h11);
        check_eq("rst_second_data", 32'(data_log[1]), 32'h33);

        // External owner holds tx_busy: arbitration blocked until it drops.
        do_reset();
        ext_busy            = 1'b1;
        bus.tx_busy         = 1'b1;
        bus.req_data[31:24] = 8'hC3;
        bus.req             = 4'b1000;
        repeat (30) step();
        check_eq("ext_block", 32'(start_cnt), 32'd0);
        check_eq("ext_idle_low", 32'(idle), 32'd0);
        ext_busy    = 1'b0;
        bus.tx_busy = model_busy;
        t_ref       = cyc;
        wait_start("ext_start_seen", 10);
        check_eq("ext_latency", 32'(cyc - t_ref), 32'd1);
        check_eq("ext_ack", 32'(bus.ack), 32'h8);
        check_eq("ext_data", 32'(bus.tx_data), 32'hC3);

        repeat (40) step();
        check_eq("ack_protocol", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
